// File: rtl/rv_32i_pkg.sv
// Shared RV32I header: opcode constants, hazard-controller state encoding
// and the operand-use decode shared by the decode-stage control logic.
package rv_32i_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } hz_state_e;

  // What an instruction reads, writes and whether it must run on a drained pipe.
  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
    logic writes_rd;
    logic serial;
  } op_use_t;

  function automatic op_use_t decode_use(input logic [6:0] opcode,
                                         input logic [2:0] funct3);
    op_use_t u;
    u = '0;
    case (opcode)
      OPC_OP: begin
        u.use_rs1   = 1'b1;
        u.use_rs2   = 1'b1;
        u.writes_rd = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        u.use_rs1 = 1'b1;
        u.use_rs2 = 1'b1;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        u.use_rs1   = 1'b1;
        u.writes_rd = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        u.writes_rd = 1'b1;
      end
      OPC_SYSTEM: begin
        // funct3[2] selects the immediate (zimm) CSR forms, which read no register.
        u.use_rs1   = ~funct3[2];
        u.writes_rd = (funct3 != 3'b000);
        u.serial    = 1'b1;
      end
      OPC_FENCE: begin
        u.serial = 1'b1;
      end
      default: begin
        u = '0;
      end
    endcase
    return u;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register count of in-flight writes. Issue increments, writeback
// decrements; x0 is never tracked. Exposes counts for the three decode
// operands plus an "anything outstanding" flag.
module hazard_scoreboard
  import rv_32i_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc_en,
  input  logic [REG_IDX_W-1:0] inc_idx,
  input  logic                 dec_en,
  input  logic [REG_IDX_W-1:0] dec_idx,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  input  logic [REG_IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0]     rs1_cnt,
  output logic [CNT_W-1:0]     rs2_cnt,
  output logic [CNT_W-1:0]     rd_cnt,
  output logic                 pend_any
);

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;

  // Decode the inc/dec requests into one-hot per-register strobes.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
    inc_vec = '0;
    dec_vec = '0;
    if (inc_en && inc_idx != '0) inc_vec[inc_idx] = 1'b1;
    // A writeback against an idle counter is dropped rather than wrapping.
    if (dec_en && dec_idx != '0 && cnt_q[dec_idx] != '0) dec_vec[dec_idx] = 1'b1;
  end

  // Counter bank update; simultaneous inc and dec on one register cancel out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: these counters are control state, not data storage, so every entry is reset.
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // NOTE: sequential state uses <= so all counters see pre-edge values.
        if (inc_vec[i] && !dec_vec[i])      cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (dec_vec[i] && !inc_vec[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  // OR-reduce all counters into the pipe-not-empty flag.
  always_comb begin
    pend_any = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cnt_q[i] != '0) pend_any = 1'b1;
    end
  end

  assign rs1_cnt = cnt_q[rs1_idx];
  assign rs2_cnt = cnt_q[rs2_idx];
  assign rd_cnt  = cnt_q[rd_idx];

  // A writeback should only ever retire a write that was issued.
  wb_without_issue : assert property (@(posedge clk) disable iff (!rst_n)
    (dec_en && dec_idx != '0) |-> (cnt_q[dec_idx] != '0));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage issue controller: stalls on RAW/WAW hazards from the
// in-flight write scoreboard, drains the pipe ahead of SYSTEM/FENCE, and
// holds a fixed-length flush after a taken branch or jump.
module pipeline_hazard_ctrl
  import rv_32i_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [6:0] id_opcode,
  input  logic [2:0] id_funct3,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       branch_taken,
  output logic       halt,
  output logic       flush,
  output logic       issue,
  output logic       pend_any,
  output logic [1:0] state
);

  hz_state_e        state_q, state_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  op_use_t          use_d;
  logic [CNT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt;
  logic             hazard, serialise;

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_en   (issue && use_d.writes_rd),
    .inc_idx  (id_rd),
    .dec_en   (wb_valid),
    .dec_idx  (wb_rd),
    .rs1_idx  (id_rs1),
    .rs2_idx  (id_rs2),
    .rd_idx   (id_rd),
    .rs1_cnt  (rs1_cnt),
    .rs2_cnt  (rs2_cnt),
    .rd_cnt   (rd_cnt),
    .pend_any (pend_any)
  );

  assign use_d = decode_use(id_opcode, id_funct3);

  // RAW on a pending source, or WAW when the destination counter is saturated.
  assign hazard = id_valid &&
                  ((use_d.use_rs1 && id_rs1 != '0 && rs1_cnt != '0) ||
                   (use_d.use_rs2 && id_rs2 != '0 && rs2_cnt != '0) ||
                   (use_d.writes_rd && rd_cnt == '1));

  assign serialise = id_valid && use_d.serial && pend_any;

  // State and flush-length registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next state and halt/flush; a taken branch overrides everything else.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    halt        = 1'b0;
    flush       = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (serialise) begin
          halt    = 1'b1;
          state_d = ST_DRAIN;
        end else if (hazard) begin
          halt    = 1'b1;
          state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (hazard) halt = 1'b1;
        else        state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (id_valid && pend_any) halt = 1'b1;
        else                      state_d = ST_RUN;
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (flush_cnt_q == '0) state_d = ST_RUN;
        else                   flush_cnt_d = flush_cnt_q - 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    if (branch_taken) begin
      state_d     = ST_FLUSH;
      flush_cnt_d = 4'(FLUSH_CYCLES - 1);
    end
  end

  assign issue = id_valid && !halt && !flush;
  assign state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios then
// random traffic, every cycle's outputs predicted by a behavioural model
// and queued for a separate monitor that compares at the falling edge.
module tb_pipeline_hazard_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int MAXC         = 3;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] FENCE  = 7'b0001111;

  typedef struct packed {
    logic       halt;
    logic       flush;
    logic       issue;
    logic       pend_any;
    logic [1:0] state;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [2:0] id_funct3;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       branch_taken;
  logic       halt, flush, issue, pend_any;
  logic [1:0] state;

  int   vectors     = 0;
  int   miscompares = 0;
  obs_t exp_q[$];

  // Reference model: outstanding write counts and controller mode.
  int   cnt[32];
  int   mode;        // 0 run, 1 stall, 2 drain, 3 flush
  int   flush_left;  // flush cycles still to show while in mode 3
  bit   last_halt;

  pipeline_hazard_ctrl #(
    .NUM_REGS     (32),
    .CNT_W        (2),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_funct3    (id_funct3),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .branch_taken (branch_taken),
    .halt         (halt),
    .flush        (flush),
    .issue        (issue),
    .pend_any     (pend_any),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic set_ins(input bit v, input logic [6:0] opc, input logic [2:0] f3,
                         input int r1, input int r2, input int rd);
    id_valid  = v;
    id_opcode = opc;
    id_funct3 = f3;
    id_rs1    = 5'(r1);
    id_rs2    = 5'(r2);
    id_rd     = 5'(rd);
  endtask

  // Apply one cycle: predict outputs, queue them, advance the model at the edge.
  task automatic cyc(input bit wbv, input int wbr, input bit br, input bit rstn);
    bit   u1, u2, wr, ser, pend, hz, h, f, iss, dec_ok;
    int   nmode, nleft;
    obs_t e;
    wb_valid     = wbv;
    wb_rd        = 5'(wbr);
    branch_taken = br;
    rst_n        = rstn;
    u1 = 0; u2 = 0; wr = 0; ser = 0;
    if (id_opcode inside {OP, STORE, BRANCH}) begin u1 = 1; u2 = 1; end
    if (id_opcode inside {OPIMM, LOAD, JALR}) u1 = 1;
    if (id_opcode == SYSTEM && id_funct3[2] == 1'b0) u1 = 1;
    if (id_opcode inside {OP, OPIMM, LOAD, LUI, AUIPC, JAL, JALR}) wr = 1;
    if (id_opcode == SYSTEM && id_funct3 != 3'd0) wr = 1;
    if (id_opcode inside {SYSTEM, FENCE}) ser = 1;
    pend = 0;
    foreach (cnt[i]) if (cnt[i] != 0) pend = 1;
    hz = id_valid && ((u1 && id_rs1 != 0 && cnt[id_rs1] > 0) ||
                      (u2 && id_rs2 != 0 && cnt[id_rs2] > 0) ||
                      (wr && id_rd != 0 && cnt[id_rd] == MAXC));
    h = 0; f = 0; nmode = mode; nleft = flush_left;
    if (mode == 3) begin
      f = 1;
      nleft = flush_left - 1;
      if (nleft == 0) nmode = 0;
    end else if (mode == 2) begin
      if (id_valid && pend) h = 1; else nmode = 0;
    end else if (mode == 1) begin
      if (hz) h = 1; else nmode = 0;
    end else begin
      if (id_valid && ser && pend) begin h = 1; nmode = 2; end
      else if (hz) begin h = 1; nmode = 1; end
    end
    if (br) begin nmode = 3; nleft = FLUSH_CYCLES; end
    iss = id_valid && !h && !f;
    e.halt = h; e.flush = f; e.issue = iss; e.pend_any = pend; e.state = 2'(mode);
    exp_q.push_back(e);
    last_halt = h;
    dec_ok = wbv && wbr != 0 && cnt[wbr] > 0;
    @(posedge clk);
    if (!rstn) begin
      foreach (cnt[i]) cnt[i] = 0;
      mode = 0;
      flush_left = 0;
    end else begin
      if (iss && wr && id_rd != 0) cnt[id_rd] = cnt[id_rd] + 1;
      if (dec_ok) cnt[wbr] = cnt[wbr] - 1;
      mode = nmode;
      flush_left = nleft;
    end
    #1;
  endtask

  task automatic idle(input int n);
    set_ins(0, 7'd0, 3'd0, 0, 0, 0);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1);
  endtask

  // Retire every write the model still holds outstanding.
  task automatic drain_all();
    set_ins(0, 7'd0, 3'd0, 0, 0, 0);
    for (int r = 1; r < 32; r++) begin
      while (cnt[r] > 0) cyc(1, r, 0, 1);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest prediction each cycle.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{halt, flush, issue, pend_any, state};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs @%0t: got halt=%b flush=%b issue=%b pend_any=%b state=%0d, want halt=%b flush=%b issue=%b pend_any=%b state=%0d",
                   $time, a.halt, a.flush, a.issue, a.pend_any, a.state,
                   e.halt, e.flush, e.issue, e.pend_any, e.state);
        end
      end
    end
  end

  initial begin
    int live[$];
    int pick;
    foreach (cnt[i]) cnt[i] = 0;
    mode = 0; flush_left = 0; last_halt = 0;
    set_ins(0, 7'd0, 3'd0, 0, 0, 0);
    wb_valid = 0; wb_rd = 0; branch_taken = 0; rst_n = 0;
    @(posedge clk); #1;
    cyc(0, 0, 0, 0);                       // reset state observed

    // 1: RAW on x5, released by writeback
    set_ins(1, OP, 3'd0, 1, 2, 5); cyc(0, 0, 0, 1);
    set_ins(1, OP, 3'd0, 5, 1, 6); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    cyc(1, 5, 0, 1); cyc(0, 0, 0, 1);
    drain_all(); idle(1);

    // 2: x0 is never tracked
    set_ins(1, LUI, 3'd0, 0, 0, 0); cyc(0, 0, 0, 1);
    set_ins(1, OP, 3'd0, 0, 0, 1);  cyc(0, 0, 0, 1);
    drain_all(); idle(1);

    // 3: WAW saturation on x7
    set_ins(1, OPIMM, 3'd0, 0, 0, 7);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    cyc(1, 7, 0, 1); cyc(0, 0, 0, 1);
    drain_all(); idle(1);

    // 4: CSRRW and CSRRWI drain behind pending x3
    set_ins(1, OPIMM, 3'd0, 0, 0, 3);   cyc(0, 0, 0, 1);
    set_ins(1, SYSTEM, 3'b001, 0, 0, 4); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    cyc(1, 3, 0, 1); cyc(0, 0, 0, 1);
    drain_all();
    set_ins(1, OPIMM, 3'd0, 0, 0, 3);   cyc(0, 0, 0, 1);
    set_ins(1, SYSTEM, 3'b101, 9, 0, 4); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    cyc(1, 3, 0, 1); cyc(0, 0, 0, 1);
    drain_all(); idle(1);

    // 5: branch while stalled, then a second branch inside the flush window
    set_ins(1, OP, 3'd0, 1, 2, 5); cyc(0, 0, 0, 1);
    set_ins(1, OP, 3'd0, 5, 1, 6); cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1); cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    drain_all(); idle(1);

    // 6: same-cycle issue and writeback on x9, then reset in the middle of a flush
    set_ins(1, OPIMM, 3'd0, 0, 0, 9); cyc(0, 0, 0, 1);
    cyc(1, 9, 0, 1); cyc(0, 0, 0, 1);
    set_ins(0, 7'd0, 3'd0, 0, 0, 0);
    cyc(0, 0, 1, 1); cyc(0, 0, 0, 1);
    cyc(1, 9, 0, 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);

    // Random traffic on a small register window to provoke frequent hazards
    for (int n = 0; n < 3000; n++) begin
      if (!(last_halt && $urandom_range(0, 9) < 8)) begin
        logic [6:0] opcs[11];
        opcs = '{OP, OPIMM, LOAD, STORE, BRANCH, JALR, JAL, LUI, AUIPC, SYSTEM, FENCE};
        set_ins($urandom_range(0, 9) < 8, opcs[$urandom_range(0, 10)], 3'($urandom),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      end
      live.delete();
      for (int r = 1; r < 32; r++) if (cnt[r] > 0) live.push_back(r);
      pick = 0;
      if (live.size() > 0 && $urandom_range(0, 9) < 4)
        pick = live[$urandom_range(0, live.size() - 1)];
      cyc(pick != 0, pick, $urandom_range(0, 39) == 0, $urandom_range(0, 499) != 0);
    end
    idle(2);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions never compared, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
